// File: rtl/dbr_pkg.sv
// Shared constants for the data bus responder: memory-map addresses and STATUS
// register layout.
package dbr_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CHAR_W = 8;

    // Byte addresses of the peripheral registers
    localparam logic [31:0] ADDR_TXDATA = 32'h0000_1000;
    localparam logic [31:0] ADDR_STATUS = 32'h0000_1004;
    localparam logic [31:0] ADDR_COUNT  = 32'h0000_1008;

    // Word-granular forms; the two byte-offset bits never take part in decode
    localparam logic [29:0] WORD_TXDATA = ADDR_TXDATA[31:2];
    localparam logic [29:0] WORD_STATUS = ADDR_STATUS[31:2];
    localparam logic [29:0] WORD_COUNT  = ADDR_COUNT[31:2];

    // STATUS register layout; every bit not listed reads 0
    localparam int unsigned STAT_EMPTY_BIT = 0;
    localparam int unsigned STAT_FULL_BIT  = 1;
    localparam int unsigned STAT_OVF_BIT   = 2;
    localparam int unsigned STAT_CNT_LSB   = 8;
    localparam int unsigned STAT_CNT_W     = 8;

endpackage

// File: rtl/dbr_fifo.sv
// Character FIFO: registered storage, no fall-through, pointers wrap modulo DEPTH.
// A push while full is accepted only if a pop happens in the same cycle.
module dbr_fifo
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
)
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic                         accepted,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH):0]       count,
    output logic [WIDTH-1:0]             head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign accepted = do_push;
    assign count    = count_q;

    // Head is forced to zero whenever empty, so reset clears it immediately
    assign head = empty ? '0 : mem[rd_ptr_q];

    // Storage is not reset; only entries between the pointers are ever observed
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/data_bus_responder.sv
// Data-memory responder for a single-cycle CPU: word RAM plus a TX character FIFO
// with STATUS/COUNT registers. Define DBR_ACCESS_COUNT_EN to add the access counter.
module data_bus_responder
    import dbr_pkg::*;
#(
    parameter int unsigned RAM_WORDS  = 64,
    parameter int unsigned FIFO_DEPTH = 16
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              we,
    output logic [DATA_W-1:0] rdata,
    output logic [CHAR_W-1:0] char_data,
    output logic              char_valid,
    input  logic              char_ready
);

    localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0] ram [RAM_WORDS];
    logic [RAM_AW-1:0] ram_idx;
    logic              sel_ram;
    logic              sel_tx;
    logic              sel_status;
    logic              sel_count;
    logic              unused_addr_lsbs;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_accepted;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [CHAR_W-1:0] fifo_head;

    logic              overflow_q;
    logic              push_drop;
    logic [DATA_W-1:0] status_word;
    logic [DATA_W-1:0] count_word;

    // Address decode: all accesses are word accesses
    assign unused_addr_lsbs = ^addr[1:0];
    assign ram_idx          = addr[RAM_AW+1:2];

    always_comb begin
        sel_ram    = (addr[DATA_W-1:RAM_AW+2] == '0);
        sel_tx     = (addr[DATA_W-1:2] == WORD_TXDATA);
        sel_status = (addr[DATA_W-1:2] == WORD_STATUS);
        sel_count  = (addr[DATA_W-1:2] == WORD_COUNT);
    end

    // RAM has no reset; contents are undefined until written
    always_ff @(posedge clk) begin
        if (we && sel_ram) begin
            ram[ram_idx] <= wdata;
        end
    end

    assign fifo_push = we && sel_tx;
    assign fifo_pop  = char_valid && char_ready;
    assign push_drop = fifo_push && fifo_full && !fifo_pop;

    dbr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CHAR_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (wdata[CHAR_W-1:0]),
        .pop       (fifo_pop),
        .accepted  (fifo_accepted),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign char_valid = !fifo_empty;
    assign char_data  = fifo_head;

    // Sticky overflow: set by a dropped push, cleared by any STATUS write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (we && sel_status) begin
            overflow_q <= 1'b0;
        end else if (push_drop) begin
            overflow_q <= 1'b1;
        end
    end

    always_comb begin
        status_word                                 = '0;
        status_word[STAT_EMPTY_BIT]                 = fifo_empty;
        status_word[STAT_FULL_BIT]                  = fifo_full;
        status_word[STAT_OVF_BIT]                   = overflow_q;
        status_word[STAT_CNT_LSB +: STAT_CNT_W]     = STAT_CNT_W'(fifo_count);
    end

`ifdef DBR_ACCESS_COUNT_EN
    // Counts RAM stores and TXDATA bytes actually accepted into the FIFO
    logic [DATA_W-1:0] access_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            access_count_q <= '0;
        end else if (we && sel_count) begin
            access_count_q <= '0;
        end else if ((we && sel_ram) || fifo_accepted) begin
            access_count_q <= access_count_q + DATA_W'(1);
        end
    end

    assign count_word = access_count_q;
`else
    logic unused_fifo_accepted;

    assign unused_fifo_accepted = fifo_accepted;
    assign count_word           = '0;
`endif

    // Zero-latency read mux; TXDATA and unmapped addresses read as 0
    always_comb begin
        rdata = '0;
        if (sel_ram) begin
            rdata = ram[ram_idx];
        end else if (sel_status) begin
            rdata = status_word;
        end else if (sel_count) begin
            rdata = count_word;
        end
    end

endmodule

// File: doc/data_bus_responder.md
DATA_BUS_RESPONDER -- requirements
Module: data_bus_responder

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 64, giving the number of 32-bit data RAM words (power of 2, at most 1024).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, giving the output character FIFO entries (power of 2, at least 2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port addr, input, 32 bits: byte address driven by the datapath's ALU result.
REQ-006 SHALL have port wdata, input, 32 bits: store data (register RD2).
REQ-007 SHALL have port we, input, 1 bit: store strobe (MemWrite).
REQ-008 SHALL have port rdata, output, 32 bits: load data (ReadData).
REQ-009 SHALL have port char_data, output, 8 bits: FIFO head character.
REQ-010 SHALL have port char_valid, output, 1 bit: FIFO non-empty.
REQ-011 SHALL have port char_ready, input, 1 bit: the consumer accepts char_data.

Function
REQ-012 SHALL decode addr[1:0] as ignored; all accesses are word accesses.
REQ-013 SHALL map RAM to 0x0000_0000 through 4*RAM_WORDS-1, with word index addr[log2(RAM_WORDS)+1:2].
REQ-014 SHALL map TXDATA to 0x0000_1000, STATUS to 0x0000_1004, and COUNT to 0x0000_1008; every other address is unmapped.
REQ-015 SHALL return reads combinationally in the same cycle (zero latency), as the single-cycle datapath requires.
REQ-016 SHALL commit a RAM store on the rising edge where we=1, with the new value visible to reads from the next cycle.
REQ-017 SHALL push wdata[7:0] into the FIFO when a TXDATA store occurs; a TXDATA read returns 0.
REQ-018 SHALL return STATUS as: [0] empty, [1] full, [2] sticky overflow, [15:8] fill count, all other bits 0.
REQ-019 SHALL clear the overflow bit when STATUS is written (any data); no other STATUS state is writable.
REQ-020 SHALL return 0 on an unmapped read and ignore an unmapped write.
REQ-021 SHALL pop the FIFO on a rising edge where char_valid=1 and char_ready=1.
REQ-022 SHALL hold char_data stable while char_valid=1 and char_ready=0.
REQ-023 SHALL, on a push to an empty FIFO, assert char_valid on the following cycle (no fall-through).
REQ-024 SHALL, on a push when full with no pop, drop the byte, set overflow, and leave count unchanged.
REQ-025 SHALL, on a push when full with a simultaneous pop, accept the byte, leave count at FIFO_DEPTH, and not set overflow.
REQ-026 SHALL, on a simultaneous push and pop when not full, leave count unchanged.
REQ-027 SHALL wrap the read and write pointers modulo FIFO_DEPTH.

Reset
REQ-028 SHALL, on rst, immediately clear the FIFO pointers, count and overflow, and force char_valid=0 and char_data=0, including mid-transfer.
REQ-029 SHALL NOT clear RAM contents on rst; RAM is undefined until written.
REQ-030 SHALL produce rdata from the post-reset state only; it SHALL have no separate reset behaviour.

Configuration
REQ-031 SHALL, when DBR_ACCESS_COUNT_EN is defined, implement a 32-bit counter of completed RAM stores and TXDATA pushes that wraps at 2^32, reads at COUNT, is cleared by any write to COUNT, and resets to 0.
REQ-032 SHALL, when DBR_ACCESS_COUNT_EN is undefined, omit the counter and treat COUNT as unmapped (reads 0).

Structure
REQ-033 SHALL place the address constants, STATUS bit positions, and the COUNT address in shared package dbr_pkg.
REQ-034 SHALL implement the FIFO as sub-module dbr_fifo (push, pop, full, empty, count, overflow-free); decode, RAM and STATUS logic live in data_bus_responder.

Verification
REQ-035 SHALL cover: store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0010 -> rdata=0xDEADBEEF the next cycle; load 0x0000_0014 after reset -> no assertion on its value.
REQ-036 SHALL cover: store 0x41,0x42,0x43 to 0x1000 with char_ready=0, then char_ready=1 -> char_data 0x41,0x42,0x43 on consecutive cycles, after which STATUS=0x0000_0001.
REQ-037 SHALL cover: 17 TXDATA stores with char_ready=0 (depth 16) -> STATUS=0x0000_1006; write STATUS -> STATUS=0x0000_1002.
REQ-038 SHALL cover: FIFO full, TXDATA store with char_ready=1 -> count stays 16, overflow stays 0, and the new byte emerges last.
REQ-039 SHALL cover: rst asserted mid-drain with 5 entries -> char_valid=0 asynchronously and STATUS=0x0000_0001 after release.
REQ-040 SHALL cover, with DBR_ACCESS_COUNT_EN defined: 3 RAM stores plus 2 TXDATA stores -> COUNT=5; write COUNT -> COUNT=0; an unmapped write to 0x2000 -> COUNT unchanged and a read of 0x2000 returns 0.
